// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch resolution bundle: IF prediction, ID outcome,
// BTB update strobe, redirect and performance counters.
interface branch_resolve_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          pc_f;
    logic                 btb_hit;
    logic [31:0]          pred_target;
    logic                 stall_d;
    logic                 flush_d;
    logic [31:0]          pc_d;
    logic                 instr_valid_d;
    logic                 is_branch_d;
    logic                 is_jump_d;
    logic                 branch_taken_d;
    logic [31:0]          branch_target_d;
    logic                 cflow_valid;
    logic                 cflow_taken;
    logic [31:0]          cflow_target;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 pred_taken_d;
    logic [CNT_WIDTH-1:0] perf_branch_cnt;
    logic [CNT_WIDTH-1:0] perf_mispredict_cnt;

    modport master (
        output pc_f, btb_hit, pred_target,
        output stall_d, flush_d, pc_d,
        output instr_valid_d, is_branch_d, is_jump_d,
        output branch_taken_d, branch_target_d,
        input  cflow_valid, cflow_taken, cflow_target,
        input  redirect, redirect_pc, pred_taken_d,
        input  perf_branch_cnt, perf_mispredict_cnt
    );

    modport slave (
        input  pc_f, btb_hit, pred_target,
        input  stall_d, flush_d, pc_d,
        input  instr_valid_d, is_branch_d, is_jump_d,
        input  branch_taken_d, branch_target_d,
        output cflow_valid, cflow_taken, cflow_target,
        output redirect, redirect_pc, pred_taken_d,
        output perf_branch_cnt, perf_mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries the BTB prediction into ID, resolves it against the decoded
// outcome, drives redirect and the BTB update port, counts events.
module branch_resolve_unit #(
    parameter int CNT_WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_unit_if.slave bus
);
    logic                 r_pred_taken;
    logic [31:0]          r_pred_target;
    logic                 r_resolved;
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispredict_cnt;

    logic                 w_cf;
    logic                 w_actual;
    logic                 w_dir_wrong;
    logic                 w_tgt_wrong;
    logic                 w_mispredict;
    logic [31:0]          w_pc_plus4;

    assign w_cf = bus.instr_valid_d
                & (bus.is_branch_d | bus.is_jump_d)
                & ~r_resolved;
    assign w_actual     = bus.is_jump_d | bus.branch_taken_d;
    assign w_dir_wrong  = w_actual != r_pred_taken;
    assign w_tgt_wrong  = w_actual & r_pred_taken
                        & (bus.branch_target_d != r_pred_target);
    assign w_mispredict = w_cf & (w_dir_wrong | w_tgt_wrong);
    assign w_pc_plus4   = bus.pc_d + 32'd4;

    assign bus.cflow_valid  = w_cf;
    assign bus.cflow_taken  = w_actual;
    assign bus.cflow_target = bus.branch_target_d;
    assign bus.redirect     = w_mispredict;
    assign bus.redirect_pc  = w_actual ? bus.branch_target_d
                                       : w_pc_plus4;
    assign bus.pred_taken_d = r_pred_taken;

    assign bus.perf_branch_cnt     = r_branch_cnt;
    assign bus.perf_mispredict_cnt = r_mispredict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_taken     <= 1'b0;
            r_pred_target    <= 32'd0;
            r_resolved       <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (bus.flush_d) begin
                r_pred_taken  <= 1'b0;
                r_pred_target <= 32'd0;
            end else if (!bus.stall_d) begin
                r_pred_taken  <= bus.btb_hit;
                r_pred_target <= bus.pred_target;
            end

            // Remember a resolved event so a held instruction reports once
            if (bus.flush_d || !bus.stall_d) begin
                r_resolved <= 1'b0;
            end else if (w_cf) begin
                r_resolved <= 1'b1;
            end

            if (w_cf && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mispredict && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (4-bit counters so
// saturation is reachable).
module tb_branch_resolve_unit;
    localparam int W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    branch_resolve_unit_if #(.CNT_WIDTH(W)) bus ();

    branch_resolve_unit #(.CNT_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc_f            = 32'h0;
        bus.btb_hit         = 1'b0;
        bus.pred_target     = 32'h0;
        bus.stall_d         = 1'b0;
        bus.flush_d         = 1'b0;
        bus.pc_d            = 32'h10;
        bus.instr_valid_d   = 1'b0;
        bus.is_branch_d     = 1'b0;
        bus.is_jump_d       = 1'b0;
        bus.branch_taken_d  = 1'b0;
        bus.branch_target_d = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd0 ||
            bus.perf_mispredict_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
        checks++;
        if (bus.pred_taken_d !== 1'b0 || bus.redirect !== 1'b0 ||
            bus.cflow_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got pt=%b rd=%b cv=%b want 0 0 0",
                     bus.pred_taken_d, bus.redirect, bus.cflow_valid);
        end
        checks++;
        if (bus.redirect_pc !== 32'h14) begin
            errors++;
            $display("FAIL reset_rpc got %h want 00000014",
                     bus.redirect_pc);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_predicted_ok();
        idle();
        bus.btb_hit     = 1'b1;
        bus.pred_target = 32'h100;
        cyc();
        idle();
        bus.pc_d            = 32'h80;
        bus.instr_valid_d   = 1'b1;
        bus.is_branch_d     = 1'b1;
        bus.branch_taken_d  = 1'b1;
        bus.branch_target_d = 32'h100;
        #1;
        checks++;
        if (bus.cflow_valid !== 1'b1 || bus.redirect !== 1'b0 ||
            bus.pred_taken_d !== 1'b1) begin
            errors++;
            $display("FAIL hit_ok got cv=%b rd=%b pt=%b want 1 0 1",
                     bus.cflow_valid, bus.redirect, bus.pred_taken_d);
        end
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd1 ||
            bus.perf_mispredict_cnt !== 4'd0) begin
            errors++;
            $display("FAIL hit_ok_cnt got %0d/%0d want 1/0",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
    endtask

    task automatic test_mispredict_taken();
        idle();
        bus.pc_d            = 32'h200;
        bus.instr_valid_d   = 1'b1;
        bus.is_branch_d     = 1'b1;
        bus.branch_taken_d  = 1'b1;
        bus.branch_target_d = 32'h40;
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h40 ||
            bus.cflow_taken !== 1'b1 ||
            bus.cflow_target !== 32'h40) begin
            errors++;
            $display("FAIL mp_taken got rd=%b rpc=%h ct=%b tgt=%h want 1 40 1 40",
                     bus.redirect, bus.redirect_pc,
                     bus.cflow_taken, bus.cflow_target);
        end
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd2 ||
            bus.perf_mispredict_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mp_taken_cnt got %0d/%0d want 2/1",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
    endtask

    task automatic test_mispredict_not_taken();
        idle();
        bus.btb_hit     = 1'b1;
        bus.pred_target = 32'h300;
        cyc();
        idle();
        bus.pc_d            = 32'h2FC;
        bus.instr_valid_d   = 1'b1;
        bus.is_branch_d     = 1'b1;
        bus.branch_target_d = 32'h500;
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h300 ||
            bus.cflow_taken !== 1'b0) begin
            errors++;
            $display("FAIL mp_ntaken got rd=%b rpc=%h ct=%b want 1 300 0",
                     bus.redirect, bus.redirect_pc, bus.cflow_taken);
        end
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd3 ||
            bus.perf_mispredict_cnt !== 4'd2) begin
            errors++;
            $display("FAIL mp_ntaken_cnt got %0d/%0d want 3/2",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
    endtask

    task automatic test_target_mismatch();
        idle();
        bus.btb_hit     = 1'b1;
        bus.pred_target = 32'h100;
        cyc();
        idle();
        bus.pc_d            = 32'hC0;
        bus.instr_valid_d   = 1'b1;
        bus.is_branch_d     = 1'b1;
        bus.branch_taken_d  = 1'b1;
        bus.branch_target_d = 32'h104;
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h104) begin
            errors++;
            $display("FAIL tgt_mm got rd=%b rpc=%h want 1 104",
                     bus.redirect, bus.redirect_pc);
        end
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd4 ||
            bus.perf_mispredict_cnt !== 4'd3) begin
            errors++;
            $display("FAIL tgt_mm_cnt got %0d/%0d want 4/3",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
    endtask

    task automatic test_pc_wrap();
        idle();
        bus.pc_d = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (bus.redirect_pc !== 32'h0 || bus.redirect !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap got rpc=%h rd=%b want 0 0",
                     bus.redirect_pc, bus.redirect);
        end
        cyc();
    endtask

    task automatic test_stall_once();
        logic [2:0] rd_seen;
        logic [2:0] cv_seen;
        idle();
        bus.pc_d            = 32'h400;
        bus.instr_valid_d   = 1'b1;
        bus.is_jump_d       = 1'b1;
        bus.branch_target_d = 32'h800;
        bus.stall_d         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            rd_seen[i] = bus.redirect;
            cv_seen[i] = bus.cflow_valid;
            cyc();
        end
        checks++;
        if (rd_seen !== 3'b001 || cv_seen !== 3'b001) begin
            errors++;
            $display("FAIL stall_pulse got rd=%b cv=%b want 001 001",
                     rd_seen, cv_seen);
        end
        idle();
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd5 ||
            bus.perf_mispredict_cnt !== 4'd4) begin
            errors++;
            $display("FAIL stall_cnt got %0d/%0d want 5/4",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
    endtask

    task automatic test_stale_hit();
        idle();
        bus.btb_hit     = 1'b1;
        bus.pred_target = 32'h700;
        cyc();
        idle();
        bus.instr_valid_d = 1'b1;
        #1;
        checks++;
        if (bus.pred_taken_d !== 1'b1 || bus.redirect !== 1'b0 ||
            bus.cflow_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_hit got pt=%b rd=%b cv=%b want 1 0 0",
                     bus.pred_taken_d, bus.redirect, bus.cflow_valid);
        end
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd5 ||
            bus.perf_mispredict_cnt !== 4'd4) begin
            errors++;
            $display("FAIL stale_cnt got %0d/%0d want 5/4",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
    endtask

    task automatic test_flush_over_stall();
        idle();
        bus.btb_hit = 1'b1;
        cyc();
        idle();
        bus.btb_hit = 1'b1;
        bus.stall_d = 1'b1;
        bus.flush_d = 1'b1;
        cyc();
        checks++;
        if (bus.pred_taken_d !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got pt=%b want 0",
                     bus.pred_taken_d);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        bus.btb_hit     = 1'b1;
        bus.pred_target = 32'h900;
        cyc();
        idle();
        bus.instr_valid_d   = 1'b1;
        bus.is_jump_d       = 1'b1;
        bus.branch_target_d = 32'h900;
        bus.stall_d         = 1'b1;
        cyc();
        checks++;
        if (bus.cflow_valid !== 1'b0 || bus.pred_taken_d !== 1'b1) begin
            errors++;
            $display("FAIL held_quiet got cv=%b pt=%b want 0 1",
                     bus.cflow_valid, bus.pred_taken_d);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.pred_taken_d !== 1'b0 || bus.cflow_valid !== 1'b1 ||
            bus.redirect !== 1'b1 || bus.perf_branch_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_stall got pt=%b cv=%b rd=%b bc=%0d want 0 1 1 0",
                     bus.pred_taken_d, bus.cflow_valid,
                     bus.redirect, bus.perf_branch_cnt);
        end
        cyc();
        idle();
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd1 ||
            bus.perf_mispredict_cnt !== 4'd1) begin
            errors++;
            $display("FAIL rst_stall_cnt got %0d/%0d want 1/1",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
    endtask

    task automatic test_saturation();
        idle();
        bus.instr_valid_d   = 1'b1;
        bus.is_jump_d       = 1'b1;
        bus.branch_target_d = 32'hA00;
        for (int i = 0; i < 14; i++) cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd15 ||
            bus.perf_mispredict_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_reach got %0d/%0d want 15/15",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
        checks++;
        if (bus.redirect !== 1'b1) begin
            errors++;
            $display("FAIL sat_event got rd=%b want 1", bus.redirect);
        end
        cyc();
        checks++;
        if (bus.perf_branch_cnt !== 4'd15 ||
            bus.perf_mispredict_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got %0d/%0d want 15/15",
                     bus.perf_branch_cnt, bus.perf_mispredict_cnt);
        end
        idle();
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_predicted_ok();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_target_mismatch();
        test_pc_wrap();
        test_stall_once();
        test_stale_hit();
        test_flush_over_stall();
        test_reset_mid_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
